b_lut_arb: RTL and testbench
============================

# b_lut_arb

Shared-access controller for the existing combinational `b_lut` nibble-substitution unit. Two requesters share one `b_lut` instance, for example two issue slots or an instruction path plus an accelerator port. The block arbitrates round-robin, registers the operands, runs the lookup, and returns the result to the winning requester over a valid/ready response channel. One transaction is in flight at a time.

## Interface
Parameters:
- none. All widths are fixed at 32 bits, matching `b_lut`.

Ports:
- `g_clk`  in  1  system clock; all state updates on the rising edge.
- `g_resetn`  in  1  synchronous, active-low reset, sampled on the rising edge of `g_clk`.
- `req0_valid`, `req1_valid`  in  1  requester n presents an operation.
- `req0_ready`, `req1_ready`  out  1  the operation of requester n is accepted this cycle.
- `req0_crs1`, `req1_crs1`  in  32  LUT upper half, table entries 8..15.
- `req0_crs2`, `req1_crs2`  in  32  LUT lower half, table entries 0..7.
- `req0_crs3`, `req1_crs3`  in  32  eight 4-bit LUT indices.
- `rsp0_valid`, `rsp1_valid`  out  1  result available for requester n.
- `rsp0_ready`, `rsp1_ready`  in  1  requester n consumes the result.
- `rsp_result`  out  32  result, shared by both response channels; meaningful only while a `rspN_valid` is high.
- `busy`  out  1  high in any state except IDLE.

## Operation
- **Lookup function.** Let T = {crs1,crs2} (64 bits) and entry k = T[4k+3:4k].
  - result[4j+3:4j] = entry(crs3[4j+3:4j]) for j = 0..7.
  - The arbiter instantiates `b_lut` unchanged and drives it from the captured operand registers.
- **States.** IDLE, EXEC, RESP. Encoding is free.
- **IDLE:**
  - grant = the single valid requester. If both are valid, grant = the requester selected by `prio`.
  - `reqN_ready` = (state==IDLE) & grant==N & `g_resetn`. This is combinational, and at most one ready is high.
  - On handshake (valid & ready):
    - capture crs1/crs2/crs3 into operand registers;
    - `owner` <= N;
    - `prio` <= ~N;
    - go to EXEC.
  - With no valid request, remain in IDLE.
- **EXEC:** `rsp_result` <= `b_lut` output computed from the operand registers; go to RESP. No condition is checked.
- **RESP:**
  - `rsp<owner>_valid` = 1; the other `rspN_valid` = 0.
  - Hold `rsp_result` and `owner` stable until `rsp<owner>_ready`.
  - On ready, go to IDLE.
  - The other requester's `rsp_ready` is ignored.
- **Round-robin pointer `prio`.** It changes only on an accepted request. A requester that wins therefore loses the next contended grant.
- **Requester obligations:**
  - hold valid and operands stable until ready;
  - valid must not depend on ready.
- **Reset values** (applied on any edge with `g_resetn` = 0):
  - state = IDLE, `prio` = 0, `owner` = 0;
  - operand registers = 0, `rsp_result` = 0;
  - `rsp0_valid` = `rsp1_valid` = 0, `busy` = 0;
  - `req0_ready` = `req1_ready` = 0 while `g_resetn` is low.
- **Reset mid-operation.** An in-flight transaction in EXEC or RESP is dropped silently and its response is never delivered. The first acceptance after release follows `prio` = 0.

## Timing
- **Accept-to-response latency.** Handshake at edge t, then EXEC during cycle t..t+1, then `rspN_valid` high in the cycle after edge t+1 (2 cycles).
- **Minimum occupancy.** 3 cycles per operation: accept, exec, response with immediate ready. Peak throughput is 1 op / 3 cycles.
- **Response back-pressure.** A low `rsp_ready` stalls the block in RESP indefinitely. `req*_ready` stays 0 during the stall.
- **Same-cycle acceptance.** A request is never accepted in the same cycle the previous response completes. The first acceptance is the cycle after the return to IDLE.
- **Simultaneous valids.** Exactly one is granted per acceptance, and strict alternation holds under continuous contention.
- **No combinational paths from inputs to `rsp*`.** `rsp_valid` and `rsp_result` are registered; only `req*_ready` is combinational, from state, `prio`, the valids and `g_resetn`.

## Test plan
- **Identity table.** Req0 with crs1=0xFEDCBA98, crs2=0x76543210, crs3=0x01234567 -> `rsp0_valid` two cycles after accept, `rsp_result`=0x01234567, `rsp1_valid` stays 0.
- **Reversed table.** Req1 with crs1=0x01234567, crs2=0x89ABCDEF, crs3=0x0000FFFF -> `rsp1_valid`, `rsp_result`=0xFFFF0000.
- **Contention.** req0 and req1 both held valid after reset:
  - grant order 0,1,0,1;
  - each result is returned to the correct channel;
  - `req*_ready` is never high simultaneously and never high outside IDLE.
- **Back-pressure.** `rsp0_ready` held 0 for 5 cycles:
  - `rsp0_valid` and `rsp_result` remain stable;
  - `busy`=1 and `req1_ready`=0 throughout;
  - completion occurs the cycle `rsp0_ready` rises.
- **Reset mid-RESP.** `g_resetn`=0 for one edge while in RESP:
  - next cycle all `rsp*_valid`=0, `rsp_result`=0, `busy`=0;
  - no stale response appears afterwards;
  - the next contended grant goes to req0.
- **Randomised stress.** Random valids, operands and ready stalls, checked against a nibble-lookup reference model:
  - each request produces exactly one response;
  - no response is lost or duplicated.

Source files
------------

// File: rtl/b_lut_arb.sv
// Round-robin shared-access wrapper around the combinational b_lut
// nibble-substitution unit. Two requesters, one transaction in flight,
// registered operands and registered response channel.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; reqN_ready offered to the granted side
// EXEC  | operands captured; b_lut output is registered into rsp_result
// RESP  | rsp<owner>_valid high; holds until rsp<owner>_ready

// Combinational nibble lookup: T = {crs1, crs2}, entry k = T[4k+3:4k],
// result nibble j = entry(crs3 nibble j).
module b_lut (
  input  logic [31:0] crs1,
  input  logic [31:0] crs2,
  input  logic [31:0] crs3,
  output logic [31:0] result
);

  logic [63:0] lut_table;

  assign lut_table = {crs1, crs2};

  // Select one 4-bit table entry per index nibble.
  always_comb begin
    result = '0;
    for (int j = 0; j < 8; j++) begin
      result[4*j +: 4] = lut_table[{crs3[4*j +: 4], 2'b00} +: 4];
    end
  end

endmodule

module b_lut_arb (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_crs1,
  input  logic [31:0] req0_crs2,
  input  logic [31:0] req0_crs3,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_crs1,
  input  logic [31:0] req1_crs2,
  input  logic [31:0] req1_crs3,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_result,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        prio;
  logic        owner;
  logic [31:0] op_crs1;
  logic [31:0] op_crs2;
  logic [31:0] op_crs3;
  logic [31:0] lut_out;
  logic        any_req;
  logic        grant;
  logic        accept;
  logic        rsp_done;

  // A lone requester always wins; prio only breaks ties.
  assign any_req = req0_valid | req1_valid;
  assign grant   = (req0_valid & req1_valid) ? prio : req1_valid;

  b_lut u_lut (
    .crs1   (op_crs1),
    .crs2   (op_crs2),
    .crs3   (op_crs3),
    .result (lut_out)
  );

  // Next-state decode; acceptance and response completion strobes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    rsp_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_req && g_resetn) begin
          accept    = 1'b1;
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_done = owner ? rsp1_ready : rsp0_ready;
        if (rsp_done) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs: ready is the only combinational path from inputs;
  // response valids decode purely from registered state and owner.
  always_comb begin
    req0_ready = (state == ST_IDLE) & g_resetn & any_req & ~grant;
    req1_ready = (state == ST_IDLE) & g_resetn & any_req &  grant;
    rsp0_valid = (state == ST_RESP) & ~owner;
    rsp1_valid = (state == ST_RESP) &  owner;
    busy       = (state != ST_IDLE);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Arbitration pointer, owner and operand capture on acceptance.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      prio    <= 1'b0;
      owner   <= 1'b0;
      op_crs1 <= '0;
      op_crs2 <= '0;
      op_crs3 <= '0;
    end else if (accept) begin
      prio    <= ~grant;
      owner   <= grant;
      op_crs1 <= grant ? req1_crs1 : req0_crs1;
      op_crs2 <= grant ? req1_crs2 : req0_crs2;
      op_crs3 <= grant ? req1_crs3 : req0_crs3;
    end
  end

  // Result register loads once per transaction, during EXEC, and is then
  // held untouched through RESP regardless of back-pressure.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      rsp_result <= '0;
    end else if (state == ST_EXEC) begin
      rsp_result <= lut_out;
    end
  end

endmodule

// File: tb/tb_b_lut_arb.sv
// Scoreboard bench for b_lut_arb: drivers issue requests, the monitor
// predicts grant and result on each acceptance and checks every response.
module tb_b_lut_arb;

  logic        g_clk;
  logic        g_resetn;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_crs1, req0_crs2, req0_crs3;
  logic [31:0] req1_crs1, req1_crs2, req1_crs3;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp_result;
  logic        busy;

  int total = 0;
  int bad   = 0;

  bit          exp_ch_q[$];
  logic [31:0] exp_res_q[$];
  int          glog[$];
  int          accepts = 0;
  int          issued = 0;
  int          rsp_count = 0;
  int          dropped = 0;
  int          cyc = 0;
  int          acc_cyc = -100;
  bit          prio_m = 0;
  bit          prev_stall = 0;
  bit          prev_any = 0;
  bit          prev_ch = 0;
  logic [31:0] prev_res = '0;
  bit          last_ch = 0;
  logic [31:0] last_res = '0;
  bit          rand_rdy = 0;

  b_lut_arb dut (
    .g_clk      (g_clk),
    .g_resetn   (g_resetn),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_crs1  (req0_crs1),
    .req0_crs2  (req0_crs2),
    .req0_crs3  (req0_crs3),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_crs1  (req1_crs1),
    .req1_crs2  (req1_crs2),
    .req1_crs3  (req1_crs3),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_result (rsp_result),
    .busy       (busy)
  );

  initial begin
    g_clk = 0;
    forever #5 g_clk = ~g_clk;
  end

  // Reference lookup: each result nibble picks a nibble of the 64-bit table.
  function automatic logic [31:0] lut_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c);
    logic [63:0] t;
    logic [31:0] r;
    int          idx;
    t = {a, b};
    r = '0;
    for (int j = 0; j < 8; j++) begin
      idx = int'((c >> (4 * j)) & 32'hF);
      r = r | (32'((t >> (4 * idx)) & 64'hF) << (4 * j));
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard, sampling at the falling edge.
  initial begin
    int  exp_g;
    bit  any, ch, rdy;
    forever begin
      @(negedge g_clk);
      cyc++;
      if (!g_resetn) begin
        dropped += exp_ch_q.size();
        exp_ch_q.delete();
        exp_res_q.delete();
        prio_m     = 0;
        prev_stall = 0;
        prev_any   = 0;
        if (req0_ready || req1_ready) chk("ready_in_reset", {req1_ready, req0_ready}, 0);
      end else begin
        if (req0_ready && req1_ready) chk("ready_both", 1, 0);
        if (busy && (req0_ready || req1_ready)) chk("ready_not_idle", 1, 0);
        if (rsp0_valid && rsp1_valid) chk("rsp_valid_both", 1, 0);
        if (!busy && (req0_valid || req1_valid)) begin
          exp_g = (req0_valid && req1_valid) ? int'(prio_m) : (req1_valid ? 1 : 0);
          chk("grant0", req0_ready, exp_g == 0);
          chk("grant1", req1_ready, exp_g == 1);
          exp_ch_q.push_back(exp_g == 1);
          if (exp_g == 1) exp_res_q.push_back(lut_ref(req1_crs1, req1_crs2, req1_crs3));
          else            exp_res_q.push_back(lut_ref(req0_crs1, req0_crs2, req0_crs3));
          prio_m = (exp_g == 0);
          glog.push_back(exp_g);
          acc_cyc = cyc;
          accepts++;
        end
        any = rsp0_valid || rsp1_valid;
        ch  = rsp1_valid;
        rdy = ch ? rsp1_ready : rsp0_ready;
        if (any && !prev_any) chk("latency", cyc - acc_cyc, 2);
        if (prev_stall) begin
          chk("stall_hold_valid", any, 1);
          chk("stall_hold_ch", ch, prev_ch);
          chk("stall_hold_result", rsp_result, prev_res);
        end
        if (any && rdy) begin
          if (exp_ch_q.size() == 0) begin
            chk("unexpected_rsp", 1, 0);
          end else begin
            chk("rsp_channel", ch, exp_ch_q.pop_front());
            chk("rsp_result", rsp_result, exp_res_q.pop_front());
          end
          last_ch  = ch;
          last_res = rsp_result;
          rsp_count++;
        end
        prev_stall = any && !rdy;
        prev_any   = any;
        prev_ch    = ch;
        prev_res   = rsp_result;
      end
    end
  end

  // Random response back-pressure for the stress phase.
  initial begin
    forever begin
      @(posedge g_clk);
      #1;
      if (rand_rdy) begin
        rsp0_ready = ($urandom_range(0, 3) != 0);
        rsp1_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Present one operation on requester n and hold it until accepted.
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input int n, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c);
    bit acc = 0;
    if (n == 0) begin
      req0_crs1 = a; req0_crs2 = b; req0_crs3 = c; req0_valid = 1;
    end else begin
      req1_crs1 = a; req1_crs2 = b; req1_crs3 = c; req1_valid = 1;
    end
    for (int k = 0; k < 300 && !acc; k++) begin
      @(negedge g_clk);
      acc = (n == 0) ? (req0_ready === 1'b1) : (req1_ready === 1'b1);
      @(posedge g_clk);
      #1;
    end
    if (n == 0) req0_valid = 0;
    else        req1_valid = 0;
    if (acc) issued++;
    else     chk($sformatf("accept_timeout_req%0d", n), 0, 1);
  endtask

  task automatic wait_rsp(input int target);
    for (int k = 0; k < 200 && rsp_count < target; k++) @(negedge g_clk);
    if (rsp_count < target) chk("rsp_timeout", rsp_count, target);
  endtask

  task automatic wait_rsp0_valid();
    for (int k = 0; k < 50 && rsp0_valid !== 1'b1; k++) @(negedge g_clk);
    if (rsp0_valid !== 1'b1) chk("rsp0_valid_timeout", rsp0_valid, 1);
  endtask

  task automatic do_reset();
    @(posedge g_clk); #1;
    g_resetn = 0;
    @(posedge g_clk); #1;
    g_resetn = 1;
  endtask

  initial begin
    logic [31:0] held;
    int          base;
    g_resetn   = 0;
    req0_valid = 1;
    req1_valid = 0;
    req0_crs1 = '0; req0_crs2 = '0; req0_crs3 = '0;
    req1_crs1 = '0; req1_crs2 = '0; req1_crs3 = '0;
    rsp0_ready = 1;
    rsp1_ready = 1;

    // Reset state, with a request pending to prove ready is gated.
    repeat (2) @(posedge g_clk);
    @(negedge g_clk);
    chk("reset_req0_ready", req0_ready, 0);
    chk("reset_rsp0_valid", rsp0_valid, 0);
    chk("reset_rsp1_valid", rsp1_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_result", rsp_result, 0);
    @(posedge g_clk); #1;
    req0_valid = 0;
    g_resetn   = 1;

    // Identity table on requester 0.
    issue(0, 32'hFEDCBA98, 32'h76543210, 32'h01234567);
    wait_rsp(1);
    chk("identity_ch", last_ch, 0);
    chk("identity_result", last_res, 32'h01234567);

    // Reversed table on requester 1.
    @(posedge g_clk); #1;
    issue(1, 32'h01234567, 32'h89ABCDEF, 32'h0000FFFF);
    wait_rsp(2);
    chk("reversed_ch", last_ch, 1);
    chk("reversed_result", last_res, 32'hFFFF0000);

    // Contention from reset: strict alternation 0,1,0,1.
    do_reset();
    glog.delete();
    base = rsp_count;
    fork
      begin
        issue(0, $urandom, $urandom, $urandom);
        issue(0, $urandom, $urandom, $urandom);
      end
      begin
        issue(1, $urandom, $urandom, $urandom);
        issue(1, $urandom, $urandom, $urandom);
      end
    join
    wait_rsp(base + 4);
    chk("contend_count", glog.size(), 4);
    if (glog.size() == 4) begin
      chk("contend_g0", glog[0], 0);
      chk("contend_g1", glog[1], 1);
      chk("contend_g2", glog[2], 0);
      chk("contend_g3", glog[3], 1);
    end

    // Back-pressure on requester 0 with requester 1 waiting.
    @(posedge g_clk); #1;
    rsp0_ready = 0;
    glog.delete();
    base = rsp_count;
    fork
      issue(0, $urandom, $urandom, $urandom);
      issue(1, $urandom, $urandom, $urandom);
      begin
        wait_rsp0_valid();
        held = rsp_result;
        for (int i = 0; i < 5; i++) begin
          @(negedge g_clk);
          chk("bp_rsp0_valid", rsp0_valid, 1);
          chk("bp_result", rsp_result, held);
          chk("bp_busy", busy, 1);
          chk("bp_req1_ready", req1_ready, 0);
        end
        @(posedge g_clk); #1;
        rsp0_ready = 1;
        @(posedge g_clk); #1;
        chk("bp_done_busy", busy, 0);
        chk("bp_done_valid", rsp0_valid, 0);
      end
    join
    wait_rsp(base + 2);
    if (glog.size() > 0) chk("bp_first_grant", glog[0], 0);

    // Reset while in RESP: response dropped, prio back to 0.
    @(posedge g_clk); #1;
    rsp0_ready = 0;
    issue(0, $urandom, $urandom, $urandom);
    wait_rsp0_valid();
    do_reset();
    chk("rst_mid_rsp0_valid", rsp0_valid, 0);
    chk("rst_mid_rsp1_valid", rsp1_valid, 0);
    chk("rst_mid_result", rsp_result, 0);
    chk("rst_mid_busy", busy, 0);
    rsp0_ready = 1;
    base = rsp_count;
    repeat (10) @(negedge g_clk);
    chk("rst_no_stale", rsp_count, base);
    @(posedge g_clk); #1;
    glog.delete();
    fork
      issue(0, $urandom, $urandom, $urandom);
      issue(1, $urandom, $urandom, $urandom);
    join
    wait_rsp(base + 2);
    if (glog.size() > 0) chk("rst_next_grant", glog[0], 0);

    // Randomised stress with random response stalls.
    rand_rdy = 1;
    fork
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 4)) begin @(posedge g_clk); #1; end
        issue(0, $urandom, $urandom, $urandom);
      end
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 4)) begin @(posedge g_clk); #1; end
        issue(1, $urandom, $urandom, $urandom);
      end
    join
    for (int k = 0; k < 500 && (exp_ch_q.size() != 0 || busy); k++) @(negedge g_clk);
    chk("drain_queue", exp_ch_q.size(), 0);
    chk("accepts_vs_issued", accepts, issued);
    chk("one_rsp_per_req", rsp_count, accepts - dropped);
    chk("dropped_by_reset", dropped, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
